// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding and
// fetch geometry constants.
`default_nettype none

package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_t;

  localparam int unsigned INST_BYTES       = 4;
  localparam int unsigned FETCH_FIFO_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_unit_fetch_fifo2.sv
// Two-entry FIFO of {pc, instruction} pairs with push, pop, flush and occupancy.
`default_nettype none

module inst_fetch_unit_fetch_fifo2 #(
  parameter int N      = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [N-1:0]      i_pc,
  input  logic [INST_W-1:0] i_inst,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [1:0]        o_count,
  output logic              o_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [N-1:0]      o_pc
);

  logic [N-1:0]      r_pc   [2];
  logic [INST_W-1:0] r_inst [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic w_push;
  logic w_pop;

  // Guard against overflow/underflow so a misbehaving caller cannot corrupt the pointers.
  assign w_push = i_push && (r_count != 2'd2);
  assign w_pop  = i_pop  && (r_count != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_pc[i]   <= '0;
        r_inst[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_pc[r_wr_ptr]   <= i_pc;
        r_inst[r_wr_ptr] <= i_inst;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);
  assign o_inst  = r_inst[r_rd_ptr];
  assign o_pc    = r_pc[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: issues word requests at the current PC, buffers
// responses in a 2-entry FIFO for decode and steps the PC on each completed fetch.
`default_nettype none

module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int N      = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      PC_Value,
  input  logic              fetch_en,
  input  logic              redirect,
  output logic              mem_req,
  output logic [N-1:0]      mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [N-1:0]      inst_pc,
  input  logic              inst_ready,
  output logic              pc_advance,
  output logic              misalign_err
);

  fetch_state_t r_state;
  logic         r_mem_req;
  logic [N-1:0] r_mem_addr;
  logic         r_misalign;

  logic [1:0]   w_count;
  logic [1:0]   w_count_next;
  logic         w_pop;
  logic         w_take;
  logic         w_has_room;
  logic         w_misaligned;

  assign w_pop        = inst_valid && inst_ready;
  // A response is kept only when it answers a live request and no flush races it.
  assign w_take       = (r_state == ST_REQ) && mem_ack && !redirect;
  assign w_count_next = w_count + 2'd1 - {1'b0, w_pop};
  assign w_has_room   = (w_count < 2'(FETCH_FIFO_DEPTH));
  assign w_misaligned = (PC_Value[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!redirect && fetch_en && w_has_room) begin
            if (w_misaligned) begin
              r_state    <= ST_ERR;
              r_misalign <= 1'b1;
            end else begin
              r_state    <= ST_REQ;
              r_mem_req  <= 1'b1;
              r_mem_addr <= PC_Value;
            end
          end
        end
        ST_REQ: begin
          if (redirect) begin
            if (mem_ack) begin
              r_state   <= ST_IDLE;
              r_mem_req <= 1'b0;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else if (mem_ack) begin
            if (fetch_en && (w_count_next < 2'(FETCH_FIFO_DEPTH))) begin
              r_mem_addr <= r_mem_addr + N'(INST_BYTES);
            end else begin
              r_state   <= ST_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // The stale response still has to be consumed before a new request may go out.
          if (mem_ack) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        ST_ERR: begin
          if (redirect) begin
            r_state    <= ST_IDLE;
            r_misalign <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  inst_fetch_unit_fetch_fifo2 #(
    .N      (N),
    .INST_W (INST_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_take),
    .i_pc    (r_mem_addr),
    .i_inst  (mem_rdata),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_count (w_count),
    .o_valid (inst_valid),
    .o_inst  (inst_out),
    .o_pc    (inst_pc)
  );

  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;
  assign pc_advance   = w_take;
  assign misalign_err = r_misalign;

endmodule

`default_nettype wire
